wr_responder: RTL

WR_RESPONDER -- requirements
Module: wr_responder

---
 rtl/wr_responder_if.sv | 44 ++++
 rtl/wr_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wr_responder_if.sv
// AXI write-channel bundle (AW, W, B) shared by the responder and its initiator.
interface wr_responder_if #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 5,
    parameter int LEN_WIDTH  = 8
);
    logic                    s_axi_AWVALID;
    logic                    s_axi_AWREADY;
    logic [ADDR_WIDTH-1:0]   s_axi_AWADDR;
    logic [ID_WIDTH-1:0]     s_axi_AWID;
    logic [LEN_WIDTH-1:0]    s_axi_AWLEN;
    logic [2:0]              s_axi_AWSIZE;
    logic [1:0]              s_axi_AWBURST;

    logic                    s_axi_WVALID;
    logic                    s_axi_WREADY;
    logic [DATA_WIDTH-1:0]   s_axi_WDATA;
    logic [DATA_WIDTH/8-1:0] s_axi_WSTRB;
    logic                    s_axi_WLAST;

    logic                    s_axi_BVALID;
    logic                    s_axi_BREADY;
    logic [1:0]              s_axi_BRESP;
    logic [ID_WIDTH-1:0]     s_axi_BID;

    modport slave (
        input  s_axi_AWVALID, s_axi_AWADDR, s_axi_AWID, s_axi_AWLEN, s_axi_AWSIZE, s_axi_AWBURST,
        output s_axi_AWREADY,
        input  s_axi_WVALID, s_axi_WDATA, s_axi_WSTRB, s_axi_WLAST,
        output s_axi_WREADY,
        output s_axi_BVALID, s_axi_BRESP, s_axi_BID,
        input  s_axi_BREADY
    );

    modport master (
        output s_axi_AWVALID, s_axi_AWADDR, s_axi_AWID, s_axi_AWLEN, s_axi_AWSIZE, s_axi_AWBURST,
        input  s_axi_AWREADY,
        output s_axi_WVALID, s_axi_WDATA, s_axi_WSTRB, s_axi_WLAST,
        input  s_axi_WREADY,
        input  s_axi_BVALID, s_axi_BRESP, s_axi_BID,
        output s_axi_BREADY
    );
endinterface

// File: rtl/wr_responder.sv
// AXI write responder: queues AW requests, sinks W beats, checks burst shape
// and returns one B response per burst, with activity counters.
module wr_responder #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 5,
    parameter int LEN_WIDTH  = 8,
    parameter int AW_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wr_responder_if.slave bus,
    input  logic          clear,
    output logic [63:0]   bursts_done,
    output logic [63:0]   beats_done,
    output logic [31:0]   err_cnt,
    output logic          idle
);
    localparam int PTR_W   = $clog2(AW_DEPTH);
    localparam int ENTRY_W = ID_WIDTH + LEN_WIDTH + 3 + 2;
    localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [AW_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic                 ready_q;
    logic [ID_WIDTH-1:0]  cur_id_q, cur_id_d;
    logic [LEN_WIDTH-1:0] cur_len_q, cur_len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 cur_err_q, cur_err_d;
    logic [63:0]          bursts_q, bursts_d, beats_q, beats_d;
    logic [31:0]          err_q, err_d;

    logic                 empty, full, push, pop, w_hs, b_hs, exp_last;
    logic [ID_WIDTH-1:0]  head_id;
    logic [LEN_WIDTH-1:0] head_len;
    logic [2:0]           head_size;
    logic [1:0]           head_burst;
    logic                 awready, wready, bvalid;
    logic [1:0]           bresp;
    logic                 unused_ok;

    // Address and write payload are accepted but never stored.
    assign unused_ok = ^{bus.s_axi_AWADDR, bus.s_axi_WDATA, bus.s_axi_WSTRB};

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push  = bus.s_axi_AWVALID && awready;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign w_hs  = (state_q == S_DATA) && bus.s_axi_WVALID;
    assign b_hs  = (state_q == S_RESP) && bus.s_axi_BREADY;
    assign exp_last = (beat_cnt_q == cur_len_q);
    assign {head_id, head_len, head_size, head_burst} = mem_q[rd_ptr_q[PTR_W-1:0]];

    // AW queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.s_axi_AWID, bus.s_axi_AWLEN,
                                           bus.s_axi_AWSIZE, bus.s_axi_AWBURST};
        end
    end

    // Queue pointers and the post-reset ready flag that gates AWREADY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: a WLAST mismatch in either direction still closes the burst.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!empty) state_d = S_DATA;
            S_DATA: if (w_hs && (bus.s_axi_WLAST || exp_last)) state_d = S_RESP;
            S_RESP: if (bus.s_axi_BREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; AWREADY looks only at registered occupancy, never a same-cycle pop.
    always_comb begin
        awready = ready_q && !full;
        wready  = (state_q == S_DATA);
        bvalid  = (state_q == S_RESP);
        bresp   = (bvalid && cur_err_q) ? 2'b10 : 2'b00;
        idle    = ready_q && (state_q == S_IDLE) && empty;
    end

    assign bus.s_axi_AWREADY = awready;
    assign bus.s_axi_WREADY  = wready;
    assign bus.s_axi_BVALID  = bvalid;
    assign bus.s_axi_BRESP   = bresp;
    assign bus.s_axi_BID     = cur_id_q;

    // Current-burst tracking: load on pop, count beats and flag shape errors.
    always_comb begin
        cur_id_d   = cur_id_q;
        cur_len_d  = cur_len_q;
        beat_cnt_d = beat_cnt_q;
        cur_err_d  = cur_err_q;
        if (pop) begin
            cur_id_d   = head_id;
            cur_len_d  = head_len;
            beat_cnt_d = '0;
            cur_err_d  = (head_size != SIZE_OK) || (head_burst != 2'b01);
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            if (bus.s_axi_WLAST != exp_last) cur_err_d = 1'b1;
        end
    end

    // Statistics counters; clear overrides any same-cycle increment.
    always_comb begin
        bursts_d = bursts_q + (b_hs ? 64'd1 : 64'd0);
        beats_d  = beats_q + (w_hs ? 64'd1 : 64'd0);
        err_d    = err_q;
        if (b_hs && cur_err_q && (err_q != '1)) err_d = err_q + 32'd1;
        if (clear) begin
            bursts_d = '0;
            beats_d  = '0;
            err_d    = '0;
        end
    end

    // Burst-tracking and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_id_q   <= '0;
            cur_len_q  <= '0;
            beat_cnt_q <= '0;
            cur_err_q  <= 1'b0;
            bursts_q   <= '0;
            beats_q    <= '0;
            err_q      <= '0;
        end else begin
            cur_id_q   <= cur_id_d;
            cur_len_q  <= cur_len_d;
            beat_cnt_q <= beat_cnt_d;
            cur_err_q  <= cur_err_d;
            bursts_q   <= bursts_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
        end
    end

    assign bursts_done = bursts_q;
    assign beats_done  = beats_q;
    assign err_cnt     = err_q;
endmodule
